// File: rtl/stack_pkg.sv
// Shared stack defaults and the occupancy-counter width helper.
package stack_pkg;
  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AF_LEVEL = 12;

  // count must reach DEPTH itself, so it needs one more code than an address
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/lifo_stack_if.sv
// Stack command/data/status bundle; master drives push/pop/din/err_clr, slave is the stack.
interface lifo_stack_if #(
  parameter int WIDTH = stack_pkg::DEF_WIDTH,
  parameter int DEPTH = stack_pkg::DEF_DEPTH
);
  logic                              push;
  logic                              pop;
  logic                              err_clr;
  logic [WIDTH-1:0]                  din;
  logic [WIDTH-1:0]                  dout;
  logic                              dout_valid;
  logic [WIDTH-1:0]                  top;
  logic [stack_pkg::cnt_w(DEPTH)-1:0] count;
  logic                              empty;
  logic                              full;
  logic                              half_full;
  logic                              almost_full;
  logic                              overflow;
  logic                              underflow;

  modport master (
    output push, pop, err_clr, din,
    input  dout, dout_valid, top, count, empty, full, half_full, almost_full,
           overflow, underflow
  );

  modport slave (
    input  push, pop, err_clr, din,
    output dout, dout_valid, top, count, empty, full, half_full, almost_full,
           overflow, underflow
  );
endinterface

// File: rtl/lifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read data follows raddr combinationally.
module lifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with registered pop data (1-cycle latency) and a combinational top peek.
// No backpressure: pushes when full and pops when empty are dropped and flagged sticky.
module lifo_stack
  import stack_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL
) (
  input logic         clk,
  input logic         rst,
  lifo_stack_if.slave s
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4) begin : g_chk_depth
    $error("lifo_stack: DEPTH must be a power of two and >= 4");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
    $error("lifo_stack: AF_LEVEL must be within 1..DEPTH");
  end

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_m1;
  logic [WIDTH-1:0] dout_q;
  logic             dv_q;
  logic             ov_q;
  logic             uf_q;
  logic [WIDTH-1:0] rdat;
  logic             is_empty, is_full;
  logic             do_push, do_pop, do_swap, do_bypass, ram_we;
  logic [AW-1:0]    waddr;

  assign cnt_m1   = cnt - CW'(1);
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));

  assign do_push   = s.push & ~s.pop & ~is_full;
  assign do_pop    = s.pop & ~s.push & ~is_empty;
  assign do_swap   = s.push & s.pop & ~is_empty;
  assign do_bypass = s.push & s.pop & is_empty;

  // A swap overwrites the current top in place; a plain push fills the next slot.
  assign ram_we = (do_push | do_swap) & ~rst;
  assign waddr  = do_swap ? cnt_m1[AW-1:0] : cnt[AW-1:0];

  lifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (s.din),
    .raddr (cnt_m1[AW-1:0]),
    .rdata (rdat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ov_q   <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      dv_q <= do_pop | do_swap | do_bypass;
      if (do_pop || do_swap) dout_q <= rdat;
      else if (do_bypass)    dout_q <= s.din;
      if (do_push)     cnt <= cnt + CW'(1);
      else if (do_pop) cnt <= cnt_m1;
      // set wins over a simultaneous clear
      ov_q <= (s.push & ~s.pop & is_full)  | (ov_q & ~s.err_clr);
      uf_q <= (s.pop & ~s.push & is_empty) | (uf_q & ~s.err_clr);
    end
  end

  assign s.dout        = dout_q;
  assign s.dout_valid  = dv_q;
  assign s.top         = is_empty ? '0 : rdat;
  assign s.count       = cnt;
  assign s.empty       = is_empty;
  assign s.full        = is_full;
  assign s.half_full   = (cnt >= CW'(DEPTH / 2));
  assign s.almost_full = (cnt >= CW'(AF_LEVEL));
  assign s.overflow    = ov_q;
  assign s.underflow   = uf_q;
endmodule
